// File: rtl/stack_ctrl_if.sv
// Request/response bundle between the stack controller and its producer/consumer.
interface stack_ctrl_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ADDRWIDTH = 10
);
  logic                 Push;
  logic                 Pop;
  logic [DATAWIDTH-1:0] DIn;
  logic                 ClrErr;
  logic [DATAWIDTH-1:0] DOut;
  logic                 DOutValid;
  logic [ADDRWIDTH:0]   Count;
  logic                 Empty;
  logic                 Full;
  logic                 Overflow;
  logic                 Underflow;

  // Requester side: issues push/pop, observes data and status.
  modport master (
    output Push, Pop, DIn, ClrErr,
    input  DOut, DOutValid, Count, Empty, Full, Overflow, Underflow
  );

  // Stack side: serves requests, drives data and status.
  modport slave (
    input  Push, Pop, DIn, ClrErr,
    output DOut, DOutValid, Count, Empty, Full, Overflow, Underflow
  );
endinterface

// File: rtl/stack_ctrl.sv
// LIFO controller with internal register-file storage, occupancy tracking
// and sticky overflow/underflow flags.
module stack_ctrl #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ADDRWIDTH = 10
) (
  input  logic         Clk,
  input  logic         RstN,
  stack_ctrl_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDRWIDTH;
  localparam int unsigned CW    = ADDRWIDTH + 1;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;
  logic                 dvalid_q, dvalid_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  logic                 wr_en;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [ADDRWIDTH-1:0] top_addr;
  logic [DATAWIDTH-1:0] top_word;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  // Address of the current top entry (only meaningful when not empty).
  always_comb begin
    top_addr = ADDRWIDTH'(count_q - CW'(1));
    top_word = mem[top_addr];
  end

  // Next-state, datapath and flag decode driven by the occupancy state.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    ovf_d    = ovf_q & ~bus.ClrErr;
    udf_d    = udf_q & ~bus.ClrErr;
    wr_en    = 1'b0;
    wr_addr  = '0;

    case (state_q)
      ST_EMPTY: begin
        if (bus.Push && bus.Pop) begin
          // Nothing stored: the pushed word passes straight through.
          dout_d   = bus.DIn;
          dvalid_d = 1'b1;
        end else if (bus.Push) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          count_d = CW'(1);
        end else if (bus.Pop) begin
          udf_d = 1'b1;
        end
      end

      ST_PARTIAL, ST_FULL: begin
        if (bus.Push && bus.Pop) begin
          // Swap the top entry: old word out, new word in its slot.
          dout_d   = top_word;
          dvalid_d = 1'b1;
          wr_en    = 1'b1;
          wr_addr  = top_addr;
        end else if (bus.Push) begin
          if (state_q == ST_FULL) begin
            ovf_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_addr = ADDRWIDTH'(count_q);
            count_d = count_q + CW'(1);
          end
        end else if (bus.Pop) begin
          dout_d   = top_word;
          dvalid_d = 1'b1;
          count_d  = count_q - CW'(1);
        end
      end

      default: begin
        state_d = ST_EMPTY;
        count_d = '0;
      end
    endcase

    // Status follows the committed occupancy so the flags never disagree with Count.
    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if (count_d == COUNT_MAX) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_PARTIAL;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == COUNT_MAX);
  end

  // State and output registers; reset drops any pending pop result.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_q  <= ST_EMPTY;
      count_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; contents survive reset but no write happens while in reset.
  always_ff @(posedge Clk) begin
    if (RstN && wr_en) begin
      mem[wr_addr] <= bus.DIn;
    end
  end

  // Drive the registered results onto the bus.
  always_comb begin
    bus.DOut      = dout_q;
    bus.DOutValid = dvalid_q;
    bus.Count     = count_q;
    bus.Empty     = empty_q;
    bus.Full      = full_q;
    bus.Overflow  = ovf_q;
    bus.Underflow = udf_q;
  end

endmodule
